// File: rtl/uart_tx_periph_pkg.sv
// uart_tx_periph_pkg: serializer state codes, register offsets and STATUS bit positions.
package uart_tx_periph_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam int SB_BUSY  = 0;
    localparam int SB_FULL  = 1;
    localparam int SB_EMPTY = 2;
    localparam int SB_OVF   = 3;
    localparam int SB_PAR   = 4;
endpackage

// File: rtl/uart_tx_periph_if.sv
// uart_tx_periph_if: core data-bus view of the UART transmitter (select, store, address, data).
interface uart_tx_periph_if;
    logic        IntorPeri;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    modport master(output IntorPeri, MemWrite, Addr, WD, input RD);
    modport slave(input IntorPeri, MemWrite, Addr, WD, output RD);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x 8 synchronous FIFO; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO and STATUS register.
// Define UART_PARITY_EN to insert an even-parity bit (8E1) and report it in STATUS bit 4.
module uart_tx_periph
    import uart_tx_periph_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic             CLK,
    input  logic             CLR,
    uart_tx_periph_if.slave  bus,
    output logic             TX,
    output logic             TxIrq
);
`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        ovf_q, ovf_d, tx_q, tx_d, irq_q, irq_d;
    logic        sel, is_stat, wr_data, wr_stat, pop, full, empty;
    logic [7:0]  fifo_rd;
    logic [31:0] status;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic        unused_bits;
    assign unused_bits = ^{bus.WD[31:8], bus.Addr[1:0]};
    assign sel     = bus.IntorPeri & (bus.Addr[31:3] == BASE_ADDR[31:3]);
    assign is_stat = bus.Addr[2] == REG_STATUS[2];
    assign wr_data = sel & bus.MemWrite & (bus.Addr[2] == REG_TXDATA[2]);
    assign wr_stat = sel & bus.MemWrite & is_stat;
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (wr_data),
        .pop   (pop),
        .wdata (bus.WD[7:0]),
        .rdata (fifo_rd),
        .full  (full),
        .empty (empty),
        .count (unused_count)
    );
    // A dropped push sets ovf even if the same cycle also writes a clear.
    assign ovf_d = (wr_data & full) ? 1'b1 : (wr_stat & bus.WD[SB_OVF]) ? 1'b0 : ovf_q;
    always_comb begin
        status         = '0;
        status[SB_BUSY]  = state_q != ST_IDLE;
        status[SB_FULL]  = full;
        status[SB_EMPTY] = empty;
        status[SB_OVF]   = ovf_q;
        status[SB_PAR]   = PAR_EN;
        bus.RD = (sel & is_stat) ? status : '0;
    end
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!empty) begin
                pop     = 1'b1;
                shreg_d = fifo_rd;
                baud_d  = BAUD_MAX;
                state_d = ST_START;
            end
        end else if (baud_q != '0) begin
            baud_d = baud_q - 1'b1;
        end else begin
            baud_d = BAUD_MAX;
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
                ST_DATA: begin
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? (PAR_EN ? ST_PARITY : ST_STOP) : ST_DATA;
                end
                ST_PARITY: state_d = ST_STOP;
                default:   state_d = ST_IDLE;
            endcase
        end
    end
    // Line and irq are registered from the current state, so the line lags the FSM by one cycle.
    assign tx_d = (state_q == ST_START) ? 1'b0 :
                  (state_q == ST_DATA) ? shreg_q[bit_q] :
                  (state_q == ST_PARITY) ? ^shreg_q : 1'b1;
    assign irq_d = empty & (state_q == ST_IDLE);
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
        end
    end
    assign TX    = tx_q;
    assign TxIrq = irq_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: directed and random bus traffic checked cycle by cycle against a byte-queue model.
module tb_uart_tx_periph;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1001_0000;
`ifdef UART_PARITY_EN
    localparam int   NB  = 11;
    localparam logic PAR = 1'b1;
`else
    localparam int   NB  = 10;
    localparam logic PAR = 1'b0;
`endif
    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic TX, TxIrq;
    uart_tx_periph_if bus();
    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .bus   (bus),
        .TX    (TX),
        .TxIrq (TxIrq)
    );
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q[$];
    int n = 0;
    int last_pop = -1000;
    logic [7:0] last_byte = 8'h00;
    logic ovf = 1'b0;
    logic exp_irq = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic sel_of(input logic ip, input logic [31:0] a);
        return ip && ((a >> 3) == (BASE >> 3));
    endfunction

    function automatic logic [31:0] exp_status();
        logic busy = (n - last_pop) < NB * CPB;
        return {27'b0, PAR, ovf, q.size() == 0, q.size() == DEPTH, busy};
    endfunction

    function automatic logic [31:0] exp_rd(input logic ip, input logic [31:0] a);
        return (sel_of(ip, a) && a[2]) ? exp_status() : 32'h0;
    endfunction

    // Frame starts on the line one cycle after the byte leaves the queue.
    function automatic logic exp_tx();
        int j = n - last_pop - 1;
        int k;
        if (j < 0 || j >= NB * CPB) return 1'b1;
        k = j / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return last_byte[k-1];
        if (k == NB - 1) return 1'b1;
        return ^last_byte;
    endfunction

    task automatic model_edge(input logic ip, input logic mw, input logic [31:0] a, input logic [31:0] wd);
        int sz = q.size();
        logic idle;
        n++;
        idle = (n - last_pop) > NB * CPB;
        exp_irq = (sz == 0) && idle;
        if (sz > 0 && idle) begin
            last_byte = q.pop_front();
            last_pop  = n;
        end
        if (sel_of(ip, a) && mw && !a[2]) begin
            if (sz == DEPTH) ovf = 1'b1;
            else q.push_back(wd[7:0]);
        end else if (sel_of(ip, a) && mw && a[2] && wd[3]) begin
            ovf = 1'b0;
        end
    endtask

    task automatic step(input logic ip, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic rip, input logic [31:0] ra);
        bus.IntorPeri = ip;
        bus.MemWrite  = mw;
        bus.Addr      = a;
        bus.WD        = wd;
        @(posedge CLK);
        model_edge(ip, mw, a, wd);
        #1;
        check("tx", TX, exp_tx());
        check("irq", TxIrq, exp_irq);
        bus.IntorPeri = rip;
        bus.MemWrite  = 1'b0;
        bus.Addr      = ra;
        #1;
        check("rd", bus.RD, exp_rd(rip, ra));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, a, wd, 1'b1, BASE + 4);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, BASE + 4);
    endtask

    task automatic do_reset();
        CLR = 1'b0;
        #1;
        check("rst_tx_async", TX, 1'b1);
        repeat (2) @(posedge CLK);
        #2;
        CLR = 1'b1;
        q.delete();
        ovf = 1'b0;
        last_pop = n - 1000;
        last_byte = 8'h00;
        exp_irq = 1'b1;
        bus.IntorPeri = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Addr      = BASE + 4;
        bus.WD        = 32'h0;
        #1;
        check("rst_tx", TX, 1'b1);
        check("rst_irq", TxIrq, 1'b1);
        check("rst_status", bus.RD, {27'b0, PAR, 4'h4});
    endtask

    initial begin
        logic [31:0] ra;
        bus.IntorPeri = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'h0;
        bus.WD        = 32'h0;
        #12;
        do_reset();
        wr(BASE, 32'h55);
        idle(NB * CPB + 6);
        foreach (q[i]) check("q_drained", q.size(), 0);
        wr(BASE, 32'hA1);
        wr(BASE + 1, 32'hB2);
        wr(BASE + 2, 32'hC3);
        wr(BASE + 3, 32'hD4);
        wr(BASE, 32'hE5);
        wr(BASE, 32'hF6);
        wr(BASE, 32'h07);
        check("ovf_status", bus.RD, {27'b0, PAR, 4'hB});
        wr(BASE + 4, 32'h8);
        check("ovf_clear", bus.RD, {27'b0, PAR, 4'h3});
        step(1'b0, 1'b1, BASE, 32'h99, 1'b1, BASE + 4);
        check("unsel_nopush", bus.RD, {27'b0, PAR, 4'h3});
        idle(5 * (NB * CPB + 1) + 10);
        wr(BASE, 32'h3C);
        for (int i = 0; i < 100 && (n - last_pop - 1) < 4 * CPB; i++) idle(1);
        check("seek_bit3", (n - last_pop - 1) >= 4 * CPB, 1'b1);
        do_reset();
        idle(NB * CPB + 10);
        wr(BASE, 32'h07);
        idle(NB * CPB + 6);
        for (int i = 0; i < 3000; i++) begin
            int op = $urandom_range(0, 9);
            logic [31:0] wd = $urandom;
            case ($urandom_range(0, 3))
                0: ra = BASE | 32'($urandom_range(0, 3));
                1: ra = (BASE + 4) | 32'($urandom_range(0, 3));
                2: ra = BASE + 8;
                default: ra = $urandom;
            endcase
            if (op < 4) step(1'b1, 1'b1, BASE | 32'($urandom_range(0, 3)), wd, $urandom_range(0, 3) != 0, ra);
            else if (op == 4) step(1'b1, 1'b1, BASE + 4, wd, 1'b1, ra);
            else if (op == 5) step(1'b0, 1'b1, BASE, wd, 1'b1, ra);
            else if (op == 6) step(1'b1, 1'b1, BASE + 8 + 32'($urandom_range(0, 7)), wd, 1'b1, ra);
            else step(1'b0, 1'b0, 32'h0, 32'h0, $urandom_range(0, 1) != 0, ra);
        end
        idle(DEPTH * (NB * CPB + 1) + 20);
        check("final_empty", bus.RD, {27'b0, PAR, ovf, 3'b100});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
